// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the pipeline/auxiliary unit and the register-file write arbiter.
// Carries the writeback, auxiliary and decode read-select signals, plus the arbitrated write.
interface rf_write_arbiter_if;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_wsel;
    logic [31:0] aux_wdat;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;

    modport master (
        output wb_wen, wb_wsel, wb_wdat, aux_valid, aux_wsel, aux_wdat, rsel1, rsel2,
        input  aux_ready, rf_WEN, rf_wsel, rf_wdat, pend1, pend2, stall_req
    );

    modport slave (
        input  wb_wen, wb_wsel, wb_wdat, aux_valid, aux_wsel, aux_wdat, rsel1, rsel2,
        output aux_ready, rf_WEN, rf_wsel, rf_wdat, pend1, pend2, stall_req
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between writeback (always wins) and a small
// FIFO of auxiliary-unit results that drains when writeback leaves the port idle.
module rf_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input logic              CLK,
    input logic              nRST,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_C    = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic [4:0]       r_wsel [DEPTH];
    logic [31:0]      r_wdat [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [SW-1:0]    r_starve;
    logic             r_stall;
    logic             r_aux_ready;

    logic             w_push;
    logic             w_pop;
    logic             w_blocked;
    logic [CW-1:0]    w_next_count;
    logic             w_rf_wen;
    logic [4:0]       w_rf_wsel;
    logic [31:0]      w_rf_wdat;
    logic             w_pend1;
    logic             w_pend2;

    // Handshake, pop and occupancy bookkeeping; a zero destination completes the handshake only.
    always_comb begin
        w_push    = bus.aux_valid & r_aux_ready & (bus.aux_wsel != 5'd0);
        w_pop     = ~bus.wb_wen & (r_count != CW'(0));
        w_blocked = bus.wb_wen & (r_count != CW'(0));
        if (w_push && !w_pop) begin
            w_next_count = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - CW'(1);
        end else begin
            w_next_count = r_count;
        end
    end

    // FIFO storage, pointers and the registered ready flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_wsel[i] <= 5'd0;
                r_wdat[i] <= 32'd0;
            end
            r_valid     <= '0;
            r_head      <= PW'(0);
            r_tail      <= PW'(0);
            r_count     <= CW'(0);
            r_aux_ready <= 1'b1;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_push) begin
                r_wsel[r_tail]  <= bus.aux_wsel;
                r_wdat[r_tail]  <= bus.aux_wdat;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            r_count     <= w_next_count;
            r_aux_ready <= (w_next_count < DEPTH_C);
        end
    end

    // Starvation counter and stall request.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= SW'(0);
            r_stall  <= 1'b0;
        end else begin
            if (w_pop || (r_count == CW'(0))) begin
                r_starve <= SW'(0);
            end else if (w_blocked && (r_starve != STARVE_C)) begin
                r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= r_starve;
            end
            if (w_pop) begin
                r_stall <= 1'b0;
            end else if (w_blocked && (r_starve == STARVE_LAST)) begin
                r_stall <= 1'b1;
            end else begin
                r_stall <= r_stall;
            end
        end
    end

    // Write-port mux and pending-read detection on the registered FIFO contents.
    always_comb begin
        w_rf_wen  = 1'b0;
        w_rf_wsel = 5'd0;
        w_rf_wdat = 32'd0;
        w_pend1   = 1'b0;
        w_pend2   = 1'b0;
        if (bus.wb_wen) begin
            w_rf_wen  = 1'b1;
            w_rf_wsel = bus.wb_wsel;
            w_rf_wdat = bus.wb_wdat;
        end else if (r_count != CW'(0)) begin
            w_rf_wen  = 1'b1;
            w_rf_wsel = r_wsel[r_head];
            w_rf_wdat = r_wdat[r_head];
        end else begin
            w_rf_wen  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_wsel[i] == bus.rsel1) && (bus.rsel1 != 5'd0)) begin
                w_pend1 = 1'b1;
            end else begin
                w_pend1 = w_pend1;
            end
            if (r_valid[i] && (r_wsel[i] == bus.rsel2) && (bus.rsel2 != 5'd0)) begin
                w_pend2 = 1'b1;
            end else begin
                w_pend2 = w_pend2;
            end
        end
    end

    assign bus.rf_WEN    = w_rf_wen;
    assign bus.rf_wsel   = w_rf_wsel;
    assign bus.rf_wdat   = w_rf_wdat;
    assign bus.pend1     = w_pend1;
    assign bus.pend2     = w_pend2;
    assign bus.aux_ready = r_aux_ready;
    assign bus.stall_req = r_stall;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a queue-based model checked every cycle, plus
// hand-computed expectations along the directed scenarios.
module tb_rf_write_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } ent_t;

    ent_t mq[$];
    bit   m_ready  = 1'b1;
    int   m_starve = 0;
    bit   m_stall  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pend_of(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].wsel == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit wb, pop, acc;
        wb  = bus.wb_wen;
        pop = !wb && (mq.size() > 0);
        acc = bus.aux_valid && m_ready;
        if (pop || mq.size() == 0) begin
            m_starve = 0;
        end else if (wb) begin
            if (m_starve == STARVE_MAX - 1) m_stall = 1'b1;
            if (m_starve < STARVE_MAX) m_starve++;
        end
        if (pop) begin
            m_stall = 1'b0;
            void'(mq.pop_front());
        end
        if (acc && bus.aux_wsel != 5'd0) mq.push_back('{bus.aux_wsel, bus.aux_wdat});
        m_ready = (mq.size() < DEPTH);
    endtask

    // Model state update on each edge; asynchronous reset empties everything.
    initial forever begin
        @(posedge CLK);
        if (nRST) model_step();
    end

    initial forever begin
        @(negedge nRST);
        mq.delete();
        m_ready  = 1'b1;
        m_starve = 0;
        m_stall  = 1'b0;
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    initial forever begin
        bit          exp_wen;
        logic [4:0]  exp_wsel;
        logic [31:0] exp_wdat;
        @(negedge CLK);
        exp_wen  = bus.wb_wen || (mq.size() > 0);
        exp_wsel = bus.wb_wen ? bus.wb_wsel : (mq.size() > 0 ? mq[0].wsel : 5'd0);
        exp_wdat = bus.wb_wen ? bus.wb_wdat : (mq.size() > 0 ? mq[0].wdat : 32'd0);
        chk("model rf_WEN", {31'd0, bus.rf_WEN}, {31'd0, exp_wen});
        if (exp_wen) begin
            chk("model rf_wsel", {27'd0, bus.rf_wsel}, {27'd0, exp_wsel});
            chk("model rf_wdat", bus.rf_wdat, exp_wdat);
        end
        chk("model aux_ready", {31'd0, bus.aux_ready}, {31'd0, m_ready});
        chk("model stall_req", {31'd0, bus.stall_req}, {31'd0, m_stall});
        chk("model pend1", {31'd0, bus.pend1}, {31'd0, pend_of(bus.rsel1)});
        chk("model pend2", {31'd0, bus.pend2}, {31'd0, pend_of(bus.rsel2)});
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Presents one auxiliary result and holds it until accepted, bounded.
    task automatic aux_push(input logic [4:0] wsel, input logic [31:0] wdat);
        bit acc;
        acc = 1'b0;
        bus.aux_valid = 1'b1;
        bus.aux_wsel  = wsel;
        bus.aux_wdat  = wdat;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.aux_ready;
            tick();
        end
        bus.aux_valid = 1'b0;
        if (!acc) begin
            errors++;
            $display("FAIL aux_push timeout: wsel %0d not accepted within 20 cycles", wsel);
        end
    endtask

    task automatic set_wb(input bit en, input logic [4:0] wsel, input logic [31:0] wdat);
        bus.wb_wen  = en;
        bus.wb_wsel = wsel;
        bus.wb_wdat = wdat;
    endtask

    logic [4:0]  v_wb_wsel [9] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic        v_wb_wen  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_avalid  [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0]  v_awsel   [9] = '{5'd20, 5'd20, 5'd21, 5'd0, 5'd0, 5'd22, 5'd0, 5'd0, 5'd0};
    logic [4:0]  v_rsel1   [9] = '{5'd20, 5'd20, 5'd20, 5'd20, 5'd21, 5'd22, 5'd22, 5'd0, 5'd0};
    logic [4:0]  v_rsel2   [9] = '{5'd21, 5'd0, 5'd21, 5'd21, 5'd20, 5'd21, 5'd21, 5'd22, 5'd0};

    initial begin
        set_wb(1'b0, 5'd0, 32'd0);
        bus.aux_valid = 1'b0;
        bus.aux_wsel  = 5'd0;
        bus.aux_wdat  = 32'd0;
        bus.rsel1     = 5'd0;
        bus.rsel2     = 5'd0;
        tick();
        tick();
        nRST = 1'b1;
        tick();

        // 1. Reset state
        chk("reset rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        chk("reset aux_ready", {31'd0, bus.aux_ready}, 32'd1);
        chk("reset stall_req", {31'd0, bus.stall_req}, 32'd0);
        chk("reset pend1", {31'd0, bus.pend1}, 32'd0);

        // 2. Single push, drained the next cycle
        bus.aux_valid = 1'b1;
        bus.aux_wsel  = 5'd5;
        bus.aux_wdat  = 32'hDEAD;
        #1;
        chk("push latency rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        aux_push(5'd5, 32'hDEAD);
        chk("drain rf_WEN", {31'd0, bus.rf_WEN}, 32'd1);
        chk("drain rf_wsel", {27'd0, bus.rf_wsel}, 32'd5);
        chk("drain rf_wdat", bus.rf_wdat, 32'hDEAD);
        tick();
        chk("drained rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);

        // 3. Writeback holds the port while two entries wait
        set_wb(1'b1, 5'd3, 32'h3333);
        aux_push(5'd10, 32'hA);
        aux_push(5'd11, 32'hB);
        chk("full aux_ready", {31'd0, bus.aux_ready}, 32'd0);
        chk("wb wins rf_wsel", {27'd0, bus.rf_wsel}, 32'd3);
        tick();
        tick();
        chk("stall before 4", {31'd0, bus.stall_req}, 32'd0);
        tick();
        chk("stall after 4", {31'd0, bus.stall_req}, 32'd1);
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("first pop rf_wsel", {27'd0, bus.rf_wsel}, 32'd10);
        chk("first pop rf_wdat", bus.rf_wdat, 32'hA);
        tick();
        chk("stall after pop", {31'd0, bus.stall_req}, 32'd0);
        chk("second pop rf_wsel", {27'd0, bus.rf_wsel}, 32'd11);
        tick();
        chk("empty rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        chk("empty aux_ready", {31'd0, bus.aux_ready}, 32'd1);

        // 4. Pending-read detection
        set_wb(1'b1, 5'd3, 32'h3333);
        aux_push(5'd7, 32'h77);
        bus.rsel1 = 5'd7;
        bus.rsel2 = 5'd0;
        #1;
        chk("pend1 hit", {31'd0, bus.pend1}, 32'd1);
        chk("pend2 zero", {31'd0, bus.pend2}, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        tick();
        chk("pend1 after drain", {31'd0, bus.pend1}, 32'd0);
        bus.rsel1 = 5'd0;

        // 5. Destination zero is accepted but never written
        aux_push(5'd0, 32'hFFFF);
        chk("wsel0 rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        tick();
        chk("wsel0 later rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);

        // Directed table: push+pop together, duplicates, pending on both selects
        for (int i = 0; i < 9; i++) begin
            set_wb(v_wb_wen[i], v_wb_wsel[i], 32'h4000_0000 | i);
            bus.aux_valid = v_avalid[i];
            bus.aux_wsel  = v_awsel[i];
            bus.aux_wdat  = 32'hC000_0000 | i;
            bus.rsel1     = v_rsel1[i];
            bus.rsel2     = v_rsel2[i];
            tick();
        end
        bus.aux_valid = 1'b0;

        // 6. Reset pulse with two queued entries and writeback present
        set_wb(1'b1, 5'd9, 32'h99);
        aux_push(5'd12, 32'h12);
        aux_push(5'd13, 32'h13);
        bus.rsel1 = 5'd12;
        #1;
        chk("queued pend1", {31'd0, bus.pend1}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("reset wb rf_WEN", {31'd0, bus.rf_WEN}, 32'd1);
        chk("reset wb rf_wsel", {27'd0, bus.rf_wsel}, 32'd9);
        chk("reset pend1", {31'd0, bus.pend1}, 32'd0);
        chk("reset ready", {31'd0, bus.aux_ready}, 32'd1);
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("reset idle rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        tick();
        nRST = 1'b1;
        tick();
        chk("post reset rf_WEN", {31'd0, bus.rf_WEN}, 32'd0);
        tick();
        chk("post reset rf_WEN 2", {31'd0, bus.rf_WEN}, 32'd0);
        chk("post reset stall", {31'd0, bus.stall_req}, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
